mod13_up_counter: RTL and testbench



---
 rtl/mod13_up_counter.sv | 50 +++++
 tb/tb_mod13_up_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mod13_up_counter.sv
// Modulo-MODULUS up-counter with synchronous parallel load and async active-low reset.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears cntr immediately
//   load : synchronous load enable (priority over counting)
//   din  : parallel load value; values >= MODULUS load 0 instead
//   cntr : current count, registered
module mod13_up_counter #(
  parameter int unsigned MODULUS = 13,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cntr
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cntr_q;
  logic [WIDTH-1:0] cntr_d;

  // Next count: load wins; out-of-range loads collapse to 0 so the count stays legal.
  always_comb begin
    cntr_d = cntr_q;
    if (load) begin
      if (din <= CNT_MAX) begin
        cntr_d = din;
      end else begin
        cntr_d = '0;
      end
    end else if (cntr_q == CNT_MAX) begin
      cntr_d = '0;
    end else begin
      cntr_d = cntr_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntr_q <= '0;
    end else begin
      cntr_q <= cntr_d;
    end
  end

  assign cntr = cntr_q;

endmodule

// File: tb/tb_mod13_up_counter.sv
// Directed bench for mod13_up_counter with an expected-value queue.
module tb_mod13_up_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic [3:0] cntr;

  int n_tests;
  int n_fail;
  logic [3:0] exp_q[$];
  logic [3:0] model;

  mod13_up_counter #(.MODULUS(13), .WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .cntr (cntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-state, written arithmetically from the behaviour description.
  function automatic logic [3:0] ref_next(input logic [3:0] cur, input logic ld,
                                          input logic [3:0] d);
    if (ld) return (int'(d) < 13) ? d : 4'd0;
    return 4'((int'(cur) + 1) % 13);
  endfunction

  // Pop the oldest expectation and compare it with the current output.
  task automatic check_out(input string tag);
    logic [3:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got %0d", tag, cntr);
    end else begin
      e = exp_q.pop_front();
      assert (cntr === e) else begin
        n_fail++;
        $error("FAIL %s: got %0d expected %0d", tag, cntr, e);
      end
    end
  endtask

  // Drive load/din, predict, then check just after the next rising edge.
  task automatic cycle(input logic ld, input logic [3:0] d, input string tag);
    load = ld;
    din  = d;
    if (!rst) model = 4'd0;
    else      model = ref_next(model, ld, d);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model   = 4'd0;
    rst     = 1'b0;
    load    = 1'b0;
    din     = 4'd0;

    // Reset held across two negedges.
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(4'd0);
    check_out("rst_hold");

    // Release mid-cycle: nothing changes until the next rising edge.
    @(posedge clk);
    #1;
    #3 rst = 1'b1;
    #1;
    exp_q.push_back(4'd0);
    check_out("rst_release");

    // Free run through the wrap: 1..12,0,1.
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'd0, "count_wrap");

    // Single-cycle legal load of 5, then 6..12,0.
    cycle(1'b1, 4'd5, "load5");
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, "after_load5");

    // Illegal loads held for several cycles store 0.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'd13, "illegal13");
    cycle(1'b1, 4'd14, "illegal14");
    cycle(1'b1, 4'd15, "illegal15");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, "after_illegal");

    // Run up to 12, then load at wrap point.
    for (int i = 0; i < 9; i++) cycle(1'b0, 4'd0, "to_twelve");
    cycle(1'b1, 4'd3, "load_at_wrap");
    cycle(1'b1, 4'd12, "load12");
    cycle(1'b0, 4'd0, "wrap_after_load12");

    // Count to 7 then assert reset between edges.
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'd0, "to_seven");
    #3 rst = 1'b0;
    #1;
    model = 4'd0;
    exp_q.push_back(4'd0);
    check_out("async_rst");

    // Load during reset is ignored.
    cycle(1'b1, 4'd9, "load_in_rst");
    cycle(1'b1, 4'd9, "load_in_rst");
    load = 1'b0;
    #3 rst = 1'b1;
    #1;
    exp_q.push_back(4'd0);
    check_out("rst_release2");
    cycle(1'b0, 4'd0, "first_after_rst");

    // Held legal load, then release.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'd4, "held_load4");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, "after_held");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
